// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types: PC select encodings, NOP encoding and the
// packed records carried by the fetch FIFO and the in-flight tag queue.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10,
    PC_SEL_TRAP   = 2'b11
  } pc_sel_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Buffered fetch result waiting for the IF/ID register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Bookkeeping for one issued request until its response returns.
  typedef struct packed {
    logic        epoch;
    logic [31:0] pc;
  } fetch_tag_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus. The fetch stage is the master.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_stage_fifo.sv
// Small synchronous FIFO with occupancy count. Clear wins over push/pop;
// a push while full is accepted when a pop happens in the same cycle.
module if_fetch_stage_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC register, credit-limited in-order imem
// requests, epoch-tagged response buffering and the IF/ID register.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pc_stall_i,
  input  logic                    if_id_stall_i,
  input  logic                    if_id_flush_i,
  input  logic [1:0]              pc_sel_i,
  input  logic [31:0]             branch_target_i,
  input  logic [31:0]             jump_target_i,
  if_fetch_stage_if.master        imem,
  output logic                    if_id_valid_o,
  output logic [31:0]             if_id_pc_o,
  output logic [31:0]             if_id_pc4_o,
  output logic [31:0]             if_id_instr_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = CW + 1;
  localparam logic [UW-1:0] CREDIT_MAX = UW'(FIFO_DEPTH);

  logic [31:0]  pc_q, pc_d;
  logic         epoch_q, epoch_d;
  logic [CW-1:0] inflight, fifo_cnt;
  logic [UW-1:0] credit_used;
  fetch_tag_t   tag_wdata, tag_head;
  fetch_entry_t fifo_wdata, fifo_head;
  logic         req, fire, rsp, rsp_keep, fifo_pop;

  logic         if_id_valid_q;
  logic [31:0]  if_id_pc_q, if_id_pc4_q, if_id_instr_q;

  // Old-epoch fetches still hold credit until their responses drain.
  assign credit_used = UW'(inflight) + UW'(fifo_cnt);
  assign req         = rst_n && !pc_stall_i && !if_id_flush_i && (credit_used < CREDIT_MAX);
  assign fire        = req && imem.gnt;
  // A response with nothing outstanding is stray and ignored.
  assign rsp         = imem.rvalid && (inflight != '0);
  assign rsp_keep    = rsp && (tag_head.epoch == epoch_q) && !if_id_flush_i;
  assign fifo_pop    = !if_id_flush_i && !if_id_stall_i && (fifo_cnt != '0);

  assign tag_wdata   = '{epoch: epoch_q, pc: pc_q};
  assign fifo_wdata  = '{pc: tag_head.pc, instr: imem.rdata};

  assign imem.req    = req;
  assign imem.addr   = pc_q;

  // Tag queue: one entry per accepted request, occupancy is the in-flight count.
  if_fetch_stage_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fire),
    .pop_i   (rsp),
    .clear_i (1'b0),
    .wdata_i (tag_wdata),
    .rdata_o (tag_head),
    .count_o (inflight)
  );

  // Fetch FIFO: current-epoch responses waiting for IF/ID; redirect clears it.
  if_fetch_stage_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_fetch_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_keep),
    .pop_i   (fifo_pop),
    .clear_i (if_id_flush_i),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt)
  );

  // Next PC/epoch: redirect beats sequential advance; PC moves only on accepted requests.
  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (if_id_flush_i) begin
      epoch_d = ~epoch_q;
      unique case (pc_sel_e'(pc_sel_i))
        PC_SEL_SEQ:    pc_d = pc_q;
        PC_SEL_BRANCH: pc_d = branch_target_i;
        PC_SEL_JUMP:   pc_d = jump_target_i;
        PC_SEL_TRAP:   pc_d = TRAP_VEC;
      endcase
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC and epoch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  // IF/ID register: flush beats stall beats load from the fetch FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'h0;
      if_id_pc4_q   <= 32'h0;
      if_id_instr_q <= NOP_INSTR;
    end else if (if_id_flush_i) begin
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= NOP_INSTR;
    end else if (!if_id_stall_i) begin
      if (fifo_cnt != '0) begin
        if_id_valid_q <= 1'b1;
        if_id_pc_q    <= fifo_head.pc;
        if_id_pc4_q   <= fifo_head.pc + 32'd4;
        if_id_instr_q <= fifo_head.instr;
      end else begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= NOP_INSTR;
      end
    end
  end

  assign if_id_valid_o = if_id_valid_q;
  assign if_id_pc_o    = if_id_pc_q;
  assign if_id_pc4_o   = if_id_pc4_q;
  assign if_id_instr_o = if_id_instr_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: behavioural imem with random grant/latency and a
// reference model of PC sequence, credit, fetch buffer and IF/ID register.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_stall, ifid_stall, flush;
  logic [1:0]  sel;
  logic [31:0] btgt, jtgt;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

  if_fetch_stage_if imem ();

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RST_PC), .TRAP_VEC(TRAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_stall_i      (pc_stall),
    .if_id_stall_i   (ifid_stall),
    .if_id_flush_i   (flush),
    .pc_sel_i        (sel),
    .branch_target_i (btgt),
    .jump_target_i   (jtgt),
    .imem            (imem),
    .if_id_valid_o   (ifid_valid),
    .if_id_pc_o      (ifid_pc),
    .if_id_pc4_o     (ifid_pc4),
    .if_id_instr_o   (ifid_instr)
  );

  typedef struct { logic ep; logic [31:0] addr; int ready; } out_t;
  typedef struct { logic v; logic [31:0] pc; logic [31:0] pc4; logic [31:0] instr; } ifid_t;

  out_t        outs[$];
  logic [31:0] fifo_m[$];
  ifid_t       cur;
  ifid_t       sb[$];
  logic        ep_m;
  logic [31:0] ref_pc;
  int          cyc = 0;
  int          gnt_pct = 100;
  int          max_lat = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h6A00_0000;
  endfunction

  function automatic bit old_pending();
    foreach (outs[i]) if (outs[i].ep != ep_m) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    outs.delete();
    fifo_m.delete();
    sb.delete();
    ep_m   = 1'b0;
    ref_pc = RST_PC;
    cur.v = 1'b0; cur.pc = 32'h0; cur.pc4 = 32'h0; cur.instr = NOP_INSTR;
  endtask

  task automatic compare();
    ifid_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("ifid_valid", ifid_valid, e.v);
    check("ifid_pc",    ifid_pc,    e.pc);
    check("ifid_pc4",   ifid_pc4,   e.pc4);
    check("ifid_instr", ifid_instr, e.instr);
  endtask

  // One clock cycle: drive at negedge, predict, clock, compare at next negedge.
  task automatic step(input logic ps, input logic st, input logic fl, input logic [1:0] s,
                      input logic [31:0] bt, input logic [31:0] jt);
    ifid_t       nx;
    out_t        h, o;
    logic        rv, exp_req;
    logic [31:0] a;
    pc_stall = ps; ifid_stall = st; flush = fl; sel = s; btgt = bt; jtgt = jt;
    check("credit_bound", 32'(outs.size() + fifo_m.size() <= DEPTH), 32'd1);
    exp_req = !ps && !fl && (outs.size() + fifo_m.size() < DEPTH);
    rv = (outs.size() > 0) && (cyc >= outs[0].ready);
    imem.rvalid = rv;
    imem.rdata  = rv ? mem_word(outs[0].addr) : 32'hDEAD_BEEF;
    if (rv) h = outs.pop_front();
    #1;
    check("imem_req", imem.req, exp_req);
    imem.gnt = imem.req && ($urandom_range(99) < gnt_pct);
    if (imem.req) check("imem_addr", imem.addr, ref_pc);
    if (imem.req && imem.gnt) begin
      o.ep = ep_m; o.addr = ref_pc; o.ready = cyc + 1 + int'($urandom_range(max_lat));
      outs.push_back(o);
      ref_pc = ref_pc + 32'd4;
    end
    nx = cur;
    if (fl) begin
      nx.v = 1'b0; nx.instr = NOP_INSTR;
    end else if (!st) begin
      if (fifo_m.size() > 0) begin
        a = fifo_m.pop_front();
        nx.v = 1'b1; nx.pc = a; nx.pc4 = a + 32'd4; nx.instr = mem_word(a);
      end else begin
        nx.v = 1'b0; nx.instr = NOP_INSTR;
      end
    end
    if (rv && (h.ep == ep_m) && !fl) fifo_m.push_back(h.addr);
    if (fl) begin
      fifo_m.delete();
      ep_m = ~ep_m;
      case (s)
        2'b00:   ref_pc = ref_pc;
        2'b01:   ref_pc = bt;
        2'b10:   ref_pc = jt;
        default: ref_pc = TRAP;
      endcase
    end
    cur = nx;
    sb.push_back(nx);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req"},   imem.req,   32'd0);
    check({tag, "_valid"}, ifid_valid, 32'd0);
    check({tag, "_pc"},    ifid_pc,    32'h0);
    check({tag, "_pc4"},   ifid_pc4,   32'h0);
    check({tag, "_instr"}, ifid_instr, NOP_INSTR);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ps, st, fl;
    logic [1:0]  s;
    logic [31:0] t1, t2;
    bit          seen;

    rst_n = 1'b0;
    pc_stall = 1'b0; ifid_stall = 1'b0; flush = 1'b0; sel = 2'b00;
    btgt = 32'h0; jtgt = 32'h0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    // Zero-wait memory, no hazards: IF/ID shows 0,4,8 on consecutive cycles.
    gnt_pct = 100; max_lat = 0;
    for (int i = 0; i < 5; i++) begin
      idle_step();
      if (i >= 2) begin
        check("zw_valid", ifid_valid, 32'd1);
        check("zw_pc", ifid_pc, 32'((i - 2) * 4));
      end
    end

    // Hold IF/ID at pc 8 for three cycles, then release to 12.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      check("stall_hold_pc", ifid_pc, 32'h8);
    end
    idle_step();
    check("stall_release_pc", ifid_pc, 32'hC);

    // Branch redirect with two fetches in flight.
    max_lat = 3;
    for (int i = 0; i < 20 && outs.size() < 2; i++) idle_step();
    check("flush_setup_inflight", 32'(outs.size() >= 2), 32'd1);
    step(1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0200, 32'h0);
    check("flush_valid", ifid_valid, 32'd0);
    check("flush_instr", ifid_instr, NOP_INSTR);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      idle_step();
      seen = ifid_valid;
    end
    check("flush_seen_valid", 32'(seen), 32'd1);
    check("flush_first_pc", ifid_pc, 32'h0000_0200);

    // Flush, pc_stall and if_id_stall together with trap select.
    step(1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_0400, 32'h0000_0800);
    check("trap_valid", ifid_valid, 32'd0);
    check("trap_pc", imem.addr, TRAP);

    // Random grant/latency with random stalls and redirects.
    gnt_pct = 60; max_lat = 5;
    for (int i = 0; i < 1500; i++) begin
      ps = ($urandom_range(99) < 15);
      st = ($urandom_range(99) < 15);
      fl = ($urandom_range(99) < 4) && !old_pending();
      s  = 2'($urandom_range(3));
      t1 = $urandom() & 32'hFFFF_FFFC;
      t2 = ($urandom_range(7) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      step(ps, st, fl, s, t1, t2);
    end

    // Asynchronous reset while fetches are outstanding.
    gnt_pct = 100; max_lat = 4;
    for (int i = 0; i < 20 && outs.size() < 2; i++) idle_step();
    check("rst_setup_inflight", 32'(outs.size() >= 2), 32'd1);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    model_reset();
    pc_stall = 1'b0; ifid_stall = 1'b0; flush = 1'b0;
    imem.gnt = 1'b0; imem.rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    max_lat = 0;
    #1;
    check("post_rst_req", imem.req, 32'd1);
    check("post_rst_addr", imem.addr, RST_PC);
    @(negedge clk);
    for (int i = 0; i < 8; i++) idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
